// File: rtl/imem_pkg.sv
// Shared constants and FSM state type for the instruction-memory loader.
package imem_pkg;
   localparam logic [31:0] NOP = 32'h0000_0013;   // addi x0, x0, 0

   typedef enum logic {
      LOAD = 1'b0,
      RUN  = 1'b1
   } state_t;
endpackage

// File: rtl/imem_ram.sv
// Simple dual-port synchronous RAM, DEPTH x 32, registered read, array not reset.
module imem_ram #(
   parameter int DEPTH = 1024,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [31:0]   wdata,
   input  logic [AW-1:0] raddr,
   output logic [31:0]   rdata
);
   logic [31:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      rdata <= mem[raddr];
   end
endmodule

// File: rtl/imem_loader.sv
// Instruction memory: filled over a valid/ready stream in LOAD, serves fetches (1-cycle latency) in RUN.
// Optional IMEM_RANGE_CHECK_EN: out-of-range RUN fetches return NOP and set sticky range_err_o.
module imem_loader
   import imem_pkg::*;
#(
   parameter int DEPTH = 1024,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic [31:0]   im_addr_i,
   output logic [31:0]   im_dout_o,
   input  logic          ld_valid_i,
   output logic          ld_ready_o,
   input  logic [31:0]   ld_data_i,
   input  logic          ld_last_i,
   input  logic          reload_i,
   output logic          boot_done_o,
   output logic [AW:0]   ld_count_o,
   output logic          range_err_o
);
   state_t        state;
   logic [AW-1:0] wptr;
   logic          nop_sel;
   logic          accept;
   logic          oor;
   logic [31:0]   ram_rdata;
   logic          unused_addr;

   assign accept = (state == LOAD) && ld_valid_i;

`ifdef IMEM_RANGE_CHECK_EN
   logic range_err;

   assign oor         = |im_addr_i[31:AW+2];
   assign range_err_o = range_err;
   assign unused_addr = ^im_addr_i[1:0];

   // Reload wins over a simultaneous out-of-range fetch.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)
         range_err <= 1'b0;
      else if (state == RUN && reload_i)
         range_err <= 1'b0;
      else if (state == RUN && oor)
         range_err <= 1'b1;
   end
`else
   assign oor         = 1'b0;
   assign range_err_o = 1'b0;
   assign unused_addr = ^{im_addr_i[31:AW+2], im_addr_i[1:0]};
`endif

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state       <= LOAD;
         ld_ready_o  <= 1'b1;
         boot_done_o <= 1'b0;
         wptr        <= '0;
         ld_count_o  <= '0;
         nop_sel     <= 1'b1;
      end else begin
         case (state)
            LOAD: begin
               nop_sel <= 1'b1;
               if (accept) begin
                  wptr       <= wptr + 1'b1;
                  ld_count_o <= ld_count_o + 1'b1;
                  if (ld_last_i || wptr == AW'(DEPTH - 1)) begin
                     state       <= RUN;
                     ld_ready_o  <= 1'b0;
                     boot_done_o <= 1'b1;
                  end
               end
            end
            RUN: begin
               // The fetch sampled on the reload edge is still served from memory.
               nop_sel <= oor;
               if (reload_i) begin
                  state       <= LOAD;
                  ld_ready_o  <= 1'b1;
                  boot_done_o <= 1'b0;
                  wptr        <= '0;
                  ld_count_o  <= '0;
               end
            end
            default: state <= LOAD;
         endcase
      end
   end

   imem_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
      .clk   (clk_i),
      .we    (accept),
      .waddr (wptr),
      .wdata (ld_data_i),
      .raddr (im_addr_i[AW+1:2]),
      .rdata (ram_rdata)
   );

   assign im_dout_o = nop_sel ? NOP : ram_rdata;
endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: two instances (DEPTH 1024 and 8) on shared stimulus, behavioural model plus directed literals.
module tb_imem_loader;
   localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef IMEM_RANGE_CHECK_EN
   localparam bit RC = 1'b1;
`else
   localparam bit RC = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] addr = '0;
   logic        valid = 1'b0;
   logic [31:0] data = '0;
   logic        last = 1'b0;
   logic        reload = 1'b0;
   bit          go = 1'b0;

   logic [31:0] dout [2];
   logic        rdy [2];
   logic        boot [2];
   logic        err [2];
   logic [10:0] cnt_big;
   logic [3:0]  cnt_small;

   int checks = 0;
   int fails  = 0;

   always #5 clk = ~clk;

   imem_loader #(.DEPTH(1024)) u_big (
      .clk_i(clk), .rst_i(rst), .im_addr_i(addr), .im_dout_o(dout[0]),
      .ld_valid_i(valid), .ld_ready_o(rdy[0]), .ld_data_i(data), .ld_last_i(last),
      .reload_i(reload), .boot_done_o(boot[0]), .ld_count_o(cnt_big), .range_err_o(err[0])
   );

   imem_loader #(.DEPTH(8)) u_small (
      .clk_i(clk), .rst_i(rst), .im_addr_i(addr), .im_dout_o(dout[1]),
      .ld_valid_i(valid), .ld_ready_o(rdy[1]), .ld_data_i(data), .ld_last_i(last),
      .reload_i(reload), .boot_done_o(boot[1]), .ld_count_o(cnt_small), .range_err_o(err[1])
   );

   // Behavioural model: per instance, memory image plus run flag, write pointer, count, sticky error.
   int unsigned dep [2] = '{1024, 8};
   int unsigned awd [2] = '{10, 3};
   logic [31:0] mmem  [2][1024];
   bit          mknown[2][1024];
   bit          m_run [2] = '{0, 0};
   int unsigned m_wptr[2] = '{0, 0};
   int unsigned m_cnt [2] = '{0, 0};
   bit          m_err [2] = '{0, 0};
   logic [31:0] m_dout[2] = '{NOP, NOP};
   bit          m_dk  [2] = '{1, 1};

   always @(posedge clk or posedge rst) begin
      for (int i = 0; i < 2; i++) begin
         int unsigned idx;
         bit oor;
         idx = (addr >> 2) % dep[i];
         oor = (addr >> (2 + awd[i])) != 0;
         if (rst) begin
            m_run[i] = 0; m_wptr[i] = 0; m_cnt[i] = 0; m_err[i] = 0;
            m_dout[i] = NOP; m_dk[i] = 1;
         end else if (m_run[i]) begin
            if (RC && oor) begin
               m_dout[i] = NOP; m_dk[i] = 1; m_err[i] = 1;
            end else begin
               m_dout[i] = mmem[i][idx]; m_dk[i] = mknown[i][idx];
            end
            if (reload) begin
               m_run[i] = 0; m_wptr[i] = 0; m_cnt[i] = 0; m_err[i] = 0;
            end
         end else begin
            m_dout[i] = NOP; m_dk[i] = 1;
            if (valid) begin
               mmem[i][m_wptr[i]] = data;
               mknown[i][m_wptr[i]] = 1;
               m_cnt[i]++;
               if (last || m_wptr[i] == dep[i] - 1) m_run[i] = 1;
               m_wptr[i] = (m_wptr[i] + 1) % dep[i];
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (go && !rst) begin
         for (int i = 0; i < 2; i++) begin
            if (m_dk[i]) chk($sformatf("model dout[%0d]", i), dout[i], m_dout[i]);
            chk($sformatf("model ready[%0d]", i), 32'(rdy[i]), 32'(!m_run[i]));
            chk($sformatf("model boot[%0d]", i), 32'(boot[i]), 32'(m_run[i]));
            chk($sformatf("model err[%0d]", i), 32'(err[i]), 32'(m_err[i]));
         end
         chk("model count[0]", 32'(cnt_big), m_cnt[0]);
         chk("model count[1]", 32'(cnt_small), m_cnt[1]);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic beat(input logic [31:0] d, input logic l);
      valid = 1'b1; data = d; last = l;
      step();
      valid = 1'b0; last = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   task automatic do_reload();
      reload = 1'b1;
      step();
      reload = 1'b0;
   endtask

   task automatic fetch(input string name, input logic [31:0] a, input logic [31:0] exp);
      addr = a;
      step();
      chk(name, dout[0], exp);
   endtask

   initial begin
      step();
      go = 1'b1;
      step();
      rst = 1'b0;
      chk("reset dout", dout[0], NOP);
      chk("reset ready", 32'(rdy[0]), 32'd1);
      chk("reset boot", 32'(boot[0]), 32'd0);
      chk("reset count", 32'(cnt_big), 32'd0);
      chk("reset err", 32'(err[0]), 32'd0);

      // Basic 4-word load with a fetch of word 1 while still loading.
      beat(32'h11, 1'b0);
      beat(32'h22, 1'b0);
      addr = 32'd4;
      beat(32'h33, 1'b0);
      chk("load-phase fetch", dout[0], NOP);
      beat(32'h44, 1'b1);
      chk("count after 4", 32'(cnt_big), 32'd4);
      chk("boot after last", 32'(boot[0]), 32'd1);
      chk("ready after last", 32'(rdy[0]), 32'd0);
      fetch("word0", 32'd0, 32'h11);
      fetch("word1", 32'd4, 32'h22);
      fetch("word2", 32'd8, 32'h33);
      fetch("word3", 32'd12, 32'h44);

      // Reload with gaps between beats.
      do_reload();
      chk("reload ready", 32'(rdy[0]), 32'd1);
      chk("reload boot", 32'(boot[0]), 32'd0);
      chk("reload count", 32'(cnt_big), 32'd0);
      beat(32'h101, 1'b0);
      step();
      beat(32'h202, 1'b0);
      step();
      step();
      beat(32'h303, 1'b1);
      chk("gapped count", 32'(cnt_big), 32'd3);
      fetch("gapped word0", 32'd0, 32'h101);
      fetch("gapped word1", 32'd4, 32'h202);
      fetch("gapped word2", 32'd8, 32'h303);
      fetch("gapped word3 kept", 32'd12, 32'h44);

      // Nine beats without last: DEPTH=8 instance fills and stops at 8.
      do_reset();
      for (int k = 0; k < 9; k++) beat(32'h1000 + 32'(k), 1'b0);
      chk("full count small", 32'(cnt_small), 32'd8);
      chk("full ready small", 32'(rdy[1]), 32'd0);
      chk("full boot small", 32'(boot[1]), 32'd1);
      chk("big count 9", 32'(cnt_big), 32'd9);
      addr = 32'd0;
      step();
      chk("small word0", dout[1], 32'h1000);
      chk("big still nop", dout[0], NOP);
      addr = 32'd28;
      step();
      chk("small word7", dout[1], 32'h1007);

      // Reset in the middle of a load.
      do_reset();
      beat(32'h55, 1'b0);
      beat(32'h66, 1'b0);
      do_reset();
      chk("midreset count", 32'(cnt_big), 32'd0);
      beat(32'hAA, 1'b1);
      chk("midreset count 1", 32'(cnt_big), 32'd1);
      fetch("midreset word0", 32'd0, 32'hAA);
      fetch("midreset word1", 32'd4, 32'h66);

      // Upper address bits: range error or aliasing.
      fetch("range fetch", 32'h0001_0000, RC ? NOP : 32'hAA);
      chk("range err", 32'(err[0]), 32'(RC));
      fetch("after range", 32'd4, 32'h66);
      chk("range err sticky", 32'(err[0]), 32'(RC));
      do_reload();
      chk("range err cleared", 32'(err[0]), 32'd0);
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule

// File: doc/imem_loader.md
# imem_loader

Instruction-memory responder for the fetch stage. It answers the fetch stage's word address with the addressed instruction one clock later. Before execution starts, it is filled with a program over a valid/ready load stream. While the memory is being loaded it returns NOP, so the core executes harmlessly until the program is resident. It sits between the program loader (testbench or boot interface) and the fetch stage's instruction-memory port.

## Interface

Parameters:
- DEPTH, 1024: memory size in 32-bit words. Must be a power of two, at least 2.
- AW, $clog2(DEPTH): word-index width (derived; do not override).

Ports:
- clk_i  in  1  clock. All state is updated on the rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- im_addr_i  in  32  byte address from fetch. Bits [1:0] are ignored.
- im_dout_o  out  32  instruction word, registered.
- ld_valid_i  in  1  load beat valid.
- ld_ready_o  out  1  loader accepts a beat.
- ld_data_i  in  32  load beat data, i.e. the instruction word.
- ld_last_i  in  1  marks the final beat of the program.
- reload_i  in  1  single-cycle request to re-enter the load state.
- boot_done_o  out  1  program resident; the core may run.
- ld_count_o  out  AW+1  number of words written in the current load.
- range_err_o  out  1  sticky out-of-range fetch flag. It is constant 0 when the feature is compiled out.

## Operation

- State machine with two states, LOAD and RUN. Reset enters LOAD.
- LOAD:
  - ld_ready_o=1 and boot_done_o=0.
  - A beat is accepted when ld_valid_i and ld_ready_o are both high. It writes ld_data_i to word index wptr, then wptr and ld_count_o increment.
  - Transition LOAD→RUN occurs on an accepted beat when either ld_last_i=1 or wptr=DEPTH-1 (memory full). That beat is still written.
- RUN:
  - ld_ready_o=0 and boot_done_o=1. ld_valid_i is ignored.
  - reload_i=1 causes RUN→LOAD: wptr and ld_count_o clear to 0, and range_err_o clears.
  - reload_i is ignored in LOAD.
- Read path:
  - Word index = im_addr_i[AW+1:2].
  - In RUN, im_dout_o takes mem[index] on the next edge.
  - In LOAD, im_dout_o takes the NOP word 32'h0000_0013 regardless of address.
- Read/write collision: a fetch of the index being written in the same cycle can only happen in LOAD, and it returns NOP, so no bypass is needed.
- Reset values:
  - im_dout_o=32'h0000_0013.
  - ld_ready_o=1 (LOAD).
  - boot_done_o=0, ld_count_o=0, range_err_o=0, wptr=0.
- The memory array is not reset. Contents survive reset and reload until they are overwritten.
- Reset mid-load: the state returns to LOAD and wptr returns to 0. The next beat writes word 0.

## Timing

- Read latency is 1 cycle: an address presented at edge N gives data valid after edge N+1.
- Write: the beat accepted at edge N is readable by a fetch whose address is presented at any edge from N+1 on, once in RUN.
- boot_done_o rises in the cycle after the last beat is accepted. The first real instruction appears on im_dout_o one cycle after that.
- reload_i sampled at edge N gives ld_ready_o=1 and boot_done_o=0 after N. im_dout_o is NOP from edge N+1.
- Throughput during load is 1 word per cycle. There is no back-pressure other than the state.

## Configuration

- IMEM_RANGE_CHECK_EN defined:
  - A RUN fetch with any of im_addr_i[31:AW+2] nonzero returns NOP on the next edge.
  - The same fetch sets range_err_o, which stays set until reset or reload.
- IMEM_RANGE_CHECK_EN undefined:
  - The upper address bits are ignored, so addresses alias modulo DEPTH*4.
  - range_err_o is tied to 0.

## Structure

- Package imem_pkg:
  - NOP constant (32'h0000_0013).
  - State enum {LOAD, RUN}.
- Sub-module imem_ram:
  - Simple dual-port synchronous RAM, DEPTH×32.
  - Write port: we, waddr, wdata.
  - Registered read port: raddr, rdata.
  - No reset on the array.
- The top level holds the FSM, wptr/count, NOP muxing, and range check.

## Test plan

- Reset, then 4 beats 0x11,0x22,0x33,0x44 with the last beat flagged -> ld_count_o=4 and boot_done_o=1 one cycle later. Fetching addresses 0,4,8,12 returns 0x11..0x44, each one cycle after its address.
- Fetch during LOAD at address 4 (after word 1 has been written) -> im_dout_o=0x0000_0013.
- ld_valid_i pulsed every other cycle with a gap before the last beat -> only accepted beats counted, words stored contiguously.
- DEPTH=8, 9 beats without ld_last_i -> RUN entered after beat 8, beat 9 not accepted (ld_ready_o=0), ld_count_o=8.
- Reset asserted mid-load after 2 beats, then 1 beat 0xAA with the last beat flagged -> word 0 reads 0xAA, word 1 retains its old value.
- IMEM_RANGE_CHECK_EN defined, fetch 0x0001_0000 with DEPTH=1024 -> NOP returned and range_err_o=1 until reload_i. Undefined: the same fetch returns word 0 and range_err_o=0.
